// File: rtl/mux_4to1.sv
// rtl/mux_4to1.sv - one-of-four lane selector with combinational and registered outputs
module mux_4to1 #(
    parameter int LANE_W = 1
) (
    input  logic [4*LANE_W-1:0] a,
    input  logic [1:0]          sel,
    output logic [LANE_W-1:0]   y,
    input  logic                clk,
    input  logic                rst_n,
    output logic [LANE_W-1:0]   y_q,
    output logic [1:0]          sel_q
);

    // Header order keeps legacy positional (a, sel, y) instantiations valid.
    // An X/Z select falls to the default arm so y goes all-X in simulation.
    always_comb begin
        y = {LANE_W{1'bx}};
        case (sel)
            2'b00:   y = a[0*LANE_W +: LANE_W];
            2'b01:   y = a[1*LANE_W +: LANE_W];
            2'b10:   y = a[2*LANE_W +: LANE_W];
            2'b11:   y = a[3*LANE_W +: LANE_W];
            default: y = {LANE_W{1'bx}};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q   <= '0;
            sel_q <= 2'b00;
        end else begin
            y_q   <= y;
            sel_q <= sel;
        end
    end

endmodule

// File: tb/tb_mux_4to1.sv
// tb/tb_mux_4to1.sv - directed self-checking bench for mux_4to1
module tb_mux_4to1;

    logic        clk;
    logic        rst_n;
    logic [3:0]  a;
    logic [1:0]  sel;
    logic        y;
    logic        y_q;
    logic [1:0]  sel_q;

    logic [3:0]  la;
    logic [1:0]  lsel;
    logic        ly;
    logic        lclk;
    logic        lrst_n;
    logic        ly_q;
    logic [1:0]  lsel_q;

    logic [31:0] a8;
    logic [1:0]  sel8;
    logic [7:0]  y8;
    logic [7:0]  y8_q;
    logic [1:0]  sel8_q;

    int checks;
    int failures;

    mux_4to1 #(.LANE_W(1)) dut (
        .a(a), .sel(sel), .y(y), .clk(clk), .rst_n(rst_n), .y_q(y_q), .sel_q(sel_q)
    );

    // Positional hookup exercises the fixed header order a, sel, y first.
    mux_4to1 legacy (la, lsel, ly, lclk, lrst_n, ly_q, lsel_q);

    mux_4to1 #(.LANE_W(8)) dut8 (
        .a(a8), .sel(sel8), .y(y8), .clk(clk), .rst_n(rst_n), .y_q(y8_q), .sel_q(sel8_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        logic [3:0]  spot_a   [4];
        logic [1:0]  spot_sel [4];
        logic        spot_y   [4];
        logic [7:0]  lane8    [4];
        logic        exp_yq;
        logic [1:0]  exp_selq;

        checks   = 0;
        failures = 0;
        lclk     = 1'b0;
        lrst_n   = 1'b0;
        rst_n    = 1'b1;
        a        = 4'b0000;
        sel      = 2'b00;
        la       = 4'b0000;
        lsel     = 2'b00;
        a8       = 32'h0;
        sel8     = 2'b00;

        // Exhaustive sweep on both the named and positional instances.
        for (int s = 0; s < 4; s++) begin
            for (int v = 0; v < 16; v++) begin
                a    = v[3:0];
                sel  = s[1:0];
                la   = v[3:0];
                lsel = s[1:0];
                #1;
                check($sformatf("sweep s%0d a%0d", s, v), {31'd0, y}, {31'd0, a[sel]});
                check($sformatf("legacy s%0d a%0d", s, v), {31'd0, ly}, {31'd0, la[lsel]});
                #9;
            end
        end

        spot_a   = '{4'b0100, 4'b1011, 4'b1000, 4'b1110};
        spot_sel = '{2'd2,    2'd2,    2'd3,    2'd0};
        spot_y   = '{1'b1,    1'b0,    1'b1,    1'b0};
        for (int i = 0; i < 4; i++) begin
            a   = spot_a[i];
            sel = spot_sel[i];
            #1;
            check($sformatf("spot%0d", i), {31'd0, y}, {31'd0, spot_y[i]});
        end

        // Reset: outputs cleared while y still follows the inputs.
        @(negedge clk);
        rst_n = 1'b0;
        a     = 4'b1111;
        sel   = 2'd1;
        #1;
        check("rst y before edge", {31'd0, y}, 32'd1);
        @(posedge clk);
        #1;
        check("rst y_q", {31'd0, y_q}, 32'd0);
        check("rst sel_q", {30'd0, sel_q}, 32'd0);
        check("rst y during", {31'd0, y}, 32'd1);
        check("rst y8_q", {24'd0, y8_q}, 32'd0);

        // Pipeline: one-edge latency from inputs to y_q/sel_q.
        @(negedge clk);
        rst_n = 1'b1;
        a     = 4'b0010;
        sel   = 2'd1;
        @(posedge clk);
        #1;
        check("pipe y_q", {31'd0, y_q}, 32'd1);
        check("pipe sel_q", {30'd0, sel_q}, 32'd1);
        @(negedge clk);
        a = 4'b0000;
        #1;
        check("pipe y_q holds", {31'd0, y_q}, 32'd1);
        @(posedge clk);
        #1;
        check("pipe y_q clear", {31'd0, y_q}, 32'd0);

        // Random stream with a single-edge reset in the middle.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            a     = 4'($urandom_range(0, 15));
            sel   = 2'($urandom_range(0, 3));
            rst_n = (c == 10) ? 1'b0 : 1'b1;
            exp_yq   = rst_n ? a[sel] : 1'b0;
            exp_selq = rst_n ? sel : 2'b00;
            @(posedge clk);
            #1;
            check($sformatf("stream y_q c%0d", c), {31'd0, y_q}, {31'd0, exp_yq});
            check($sformatf("stream sel_q c%0d", c), {30'd0, sel_q}, {30'd0, exp_selq});
        end

        // Eight-bit lanes.
        lane8 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            rst_n = 1'b1;
            a8    = 32'hDDCCBBAA;
            sel8  = s[1:0];
            #1;
            check($sformatf("w8 y s%0d", s), {24'd0, y8}, {24'd0, lane8[s]});
            @(posedge clk);
            #1;
            check($sformatf("w8 y_q s%0d", s), {24'd0, y8_q}, {24'd0, lane8[s]});
            check($sformatf("w8 sel_q s%0d", s), {30'd0, sel8_q}, {30'd0, s[1:0]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
